// File: rtl/bl_pkg.sv
// Shared types and defaults for the bit-line address multiplexer.
package bl_pkg;

    localparam logic [1:0] ENC_IDLE  = 2'd0;
    localparam logic [1:0] ENC_BREAK = 2'd1;
    localparam logic [1:0] ENC_DRIVE = 2'd2;

    typedef enum logic [1:0] {
        IDLE  = ENC_IDLE,
        BREAK = ENC_BREAK,
        DRIVE = ENC_DRIVE
    } state_t;

    localparam logic MODE_DIRECT = 1'b0;
    localparam logic MODE_SCAN   = 1'b1;

    localparam int DEF_ADDR_W   = 3;
    localparam int DEF_NUM_CH   = 8;
    localparam int DEF_DEAD_CYC = 2;
    localparam int DEF_DWELL_W  = 8;

endpackage

// File: rtl/bl_dwell_cnt.sv
// Loadable down-counter with zero flag; times both the dead gap and the scan dwell.
module bl_dwell_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load,
    input  logic         dec,
    input  logic [W-1:0] load_val,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_val;
        end else if (dec && (count_reg != '0)) begin
            count_reg <= count_reg - 1'b1;
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/bl_mux_seq.sv
// Registered bit-line address mux: direct or scan selection with a dead gap
// (EN_out low) between any two different addresses.
module bl_mux_seq
    import bl_pkg::*;
#(
    parameter int ADDR_W   = DEF_ADDR_W,
    parameter int NUM_CH   = DEF_NUM_CH,
    parameter int DEAD_CYC = DEF_DEAD_CYC,
    parameter int DWELL_W  = DEF_DWELL_W
) (
    input  logic               Clk,
    input  logic               Reset,
    input  logic               EN_in,
    input  logic               Mode_in,
    input  logic [ADDR_W-1:0]  A_in,
    input  logic [DWELL_W-1:0] Dwell_in,
    output logic [ADDR_W-1:0]  A_out,
    output logic               EN_out,
    output logic               Busy_out,
    output logic               Done_out,
    output logic               Err_out
);

    // BREAK is entered already holding its first cycle, hence the minus one.
    localparam logic [DWELL_W-1:0] DEAD_LOAD = (DEAD_CYC > 0) ? DWELL_W'(DEAD_CYC - 1) : '0;

    state_t              state_reg, state_next;
    logic [ADDR_W-1:0]   tgt_reg, tgt_next;
    logic                mode_reg, mode_next;
    logic [ADDR_W-1:0]   a_next;
    logic                en_next, busy_next, done_next, err_next;
    logic                cnt_load, cnt_dec, cnt_zero;
    logic [DWELL_W-1:0]  cnt_val;
    logic                go_req, enter_drive, abort, new_req;
    logic [ADDR_W-1:0]   req_addr, drive_addr;
    logic                in_valid, at_last;
    logic [ADDR_W-1:0]   addr_inc;

    assign in_valid = (int'(A_in) < NUM_CH);
    assign at_last  = (int'(A_out) == NUM_CH - 1);
    assign addr_inc = at_last ? '0 : A_out + ADDR_W'(1);
    assign new_req  = (state_reg == IDLE) || (Mode_in != mode_reg);

    bl_dwell_cnt #(.W(DWELL_W)) u_cnt (
        .clk      (Clk),
        .rst_n    (Reset),
        .load     (cnt_load),
        .dec      (cnt_dec),
        .load_val (cnt_val),
        .zero     (cnt_zero)
    );

    always_comb begin
        state_next  = state_reg;
        tgt_next    = tgt_reg;
        mode_next   = mode_reg;
        a_next      = A_out;
        en_next     = EN_out;
        done_next   = 1'b0;
        err_next    = 1'b0;
        cnt_load    = 1'b0;
        cnt_dec     = 1'b0;
        cnt_val     = '0;
        go_req      = 1'b0;
        req_addr    = '0;
        enter_drive = 1'b0;
        drive_addr  = '0;
        abort       = 1'b0;

        if (!EN_in) begin
            abort = 1'b1;
        end else if (new_req) begin
            // Fresh request from IDLE, or a mode switch mid-operation.
            if (Mode_in == MODE_SCAN) begin
                mode_next = MODE_SCAN;
                go_req    = 1'b1;
            end else if (in_valid) begin
                mode_next = MODE_DIRECT;
                go_req    = 1'b1;
                req_addr  = A_in;
            end else begin
                err_next = 1'b1;
                abort    = 1'b1;
            end
        end else if (state_reg == BREAK) begin
            if (cnt_zero) begin
                enter_drive = 1'b1;
                drive_addr  = tgt_reg;
            end else begin
                cnt_dec = 1'b1;
            end
        end else if (mode_reg == MODE_DIRECT) begin
            if (!in_valid) begin
                err_next = 1'b1;
            end else if (A_in != A_out) begin
                go_req   = 1'b1;
                req_addr = A_in;
            end
        end else begin
            if (cnt_zero) begin
                go_req    = 1'b1;
                req_addr  = addr_inc;
                done_next = at_last;
            end else begin
                cnt_dec = 1'b1;
            end
        end

        if (go_req) begin
            tgt_next = req_addr;
            if (DEAD_CYC == 0) begin
                enter_drive = 1'b1;
                drive_addr  = req_addr;
            end else begin
                state_next = BREAK;
                a_next     = '0;
                en_next    = 1'b0;
                cnt_load   = 1'b1;
                cnt_val    = DEAD_LOAD;
            end
        end

        if (enter_drive) begin
            state_next = DRIVE;
            a_next     = drive_addr;
            en_next    = 1'b1;
            cnt_load   = 1'b1;
            cnt_val    = Dwell_in;
        end

        if (abort) begin
            state_next = IDLE;
            a_next     = '0;
            en_next    = 1'b0;
        end

        busy_next = (state_next == BREAK);
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_reg <= IDLE;
            tgt_reg   <= '0;
            mode_reg  <= MODE_DIRECT;
            A_out     <= '0;
            EN_out    <= 1'b0;
            Busy_out  <= 1'b0;
            Done_out  <= 1'b0;
            Err_out   <= 1'b0;
        end else begin
            state_reg <= state_next;
            tgt_reg   <= tgt_next;
            mode_reg  <= mode_next;
            A_out     <= a_next;
            EN_out    <= en_next;
            Busy_out  <= busy_next;
            Done_out  <= done_next;
            Err_out   <= err_next;
        end
    end

endmodule

// File: tb/tb_bl_mux_seq.sv
// Directed bench for bl_mux_seq: four instances with different NUM_CH/DEAD_CYC share one stimulus.
module tb_bl_mux_seq;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en;
    logic       mode;
    logic [2:0] a;
    logic [7:0] dwell;

    logic [2:0] a_o    [4];
    logic       en_o   [4];
    logic       busy_o [4];
    logic       done_o [4];
    logic       err_o  [4];

    int total = 0;
    int bad   = 0;

    int seq [13] = '{0, 0, -1, 1, 1, -1, 2, 2, -1, 3, 3, -1, 0};

    always #5 clk = ~clk;

    bl_mux_seq #(.ADDR_W(3), .NUM_CH(8), .DEAD_CYC(2), .DWELL_W(8)) u_d0 (
        .Clk(clk), .Reset(rst_n), .EN_in(en), .Mode_in(mode), .A_in(a), .Dwell_in(dwell),
        .A_out(a_o[0]), .EN_out(en_o[0]), .Busy_out(busy_o[0]), .Done_out(done_o[0]), .Err_out(err_o[0]));

    bl_mux_seq #(.ADDR_W(3), .NUM_CH(6), .DEAD_CYC(2), .DWELL_W(8)) u_d1 (
        .Clk(clk), .Reset(rst_n), .EN_in(en), .Mode_in(mode), .A_in(a), .Dwell_in(dwell),
        .A_out(a_o[1]), .EN_out(en_o[1]), .Busy_out(busy_o[1]), .Done_out(done_o[1]), .Err_out(err_o[1]));

    bl_mux_seq #(.ADDR_W(3), .NUM_CH(4), .DEAD_CYC(1), .DWELL_W(8)) u_d2 (
        .Clk(clk), .Reset(rst_n), .EN_in(en), .Mode_in(mode), .A_in(a), .Dwell_in(dwell),
        .A_out(a_o[2]), .EN_out(en_o[2]), .Busy_out(busy_o[2]), .Done_out(done_o[2]), .Err_out(err_o[2]));

    bl_mux_seq #(.ADDR_W(3), .NUM_CH(8), .DEAD_CYC(0), .DWELL_W(8)) u_d3 (
        .Clk(clk), .Reset(rst_n), .EN_in(en), .Mode_in(mode), .A_in(a), .Dwell_in(dwell),
        .A_out(a_o[3]), .EN_out(en_o[3]), .Busy_out(busy_o[3]), .Done_out(done_o[3]), .Err_out(err_o[3]));

    task automatic chk(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got={en,a,busy,done,err}=%07b exp=%07b", tag, got[6:0], exp[6:0]);
        end else begin
            $display("chk %s ok value=%07b", tag, got[6:0]);
        end
    endtask

    task automatic chk_out(input string tag, input int idx, input int e_en, input int e_a,
                           input int e_busy, input int e_done, input int e_err);
        int got;
        int exp;
        got = int'({en_o[idx], a_o[idx], busy_o[idx], done_o[idx], err_o[idx]});
        exp = e_en * 64 + e_a * 8 + e_busy * 4 + e_done * 2 + e_err;
        chk(tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        a     = 3'd0;
        dwell = 8'd0;
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        mode  = 1'b0;
        a     = 3'd0;
        dwell = 8'd0;
        tick();
        tick();
        chk_out("reset_state", 0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;

        // direct request, DEAD_CYC=2 on d0 and DEAD_CYC=0 on d3
        en = 1'b1; mode = 1'b0; a = 3'd3;
        tick();
        chk_out("dir_brk1", 0, 0, 0, 1, 0, 0);
        chk_out("dead0_drv3", 3, 1, 3, 0, 0, 0);
        tick();
        chk_out("dir_brk2", 0, 0, 0, 1, 0, 0);
        tick();
        chk_out("dir_drv3", 0, 1, 3, 0, 0, 0);
        a = 3'd6;
        tick();
        chk_out("chg_brk1", 0, 0, 0, 1, 0, 0);
        chk_out("dead0_drv6", 3, 1, 6, 0, 0, 0);
        tick();
        chk_out("chg_brk2", 0, 0, 0, 1, 0, 0);
        tick();
        chk_out("chg_drv6", 0, 1, 6, 0, 0, 0);
        tick();
        chk_out("hold6", 0, 1, 6, 0, 0, 0);

        // async reset while driving address 5
        a = 3'd5;
        tick(); tick(); tick();
        chk_out("drv5", 0, 1, 5, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 0, 0, 0, 0, 0, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk_out("rel_idle_req", 0, 0, 0, 1, 0, 0);

        // invalid address on NUM_CH=6
        do_reset();
        en = 1'b1; a = 3'd7;
        tick();
        chk_out("err_idle", 1, 0, 0, 0, 0, 1);
        a = 3'd2;
        tick();
        chk_out("err_clr_brk", 1, 0, 0, 1, 0, 0);
        tick(); tick();
        chk_out("err_drv2", 1, 1, 2, 0, 0, 0);
        a = 3'd7;
        tick();
        chk_out("err_hold", 1, 1, 2, 0, 0, 1);
        a = 3'd2;
        tick();
        chk_out("err_gone", 1, 1, 2, 0, 0, 0);

        // scan NUM_CH=4, dwell=1, DEAD_CYC=1
        do_reset();
        mode = 1'b1; dwell = 8'd1; en = 1'b1;
        tick();
        chk_out("scan_start", 2, 0, 0, 1, 0, 0);
        for (int i = 0; i < 13; i++) begin
            tick();
            chk_out($sformatf("scan_p1_%0d", i), 2, (seq[i] >= 0) ? 1 : 0,
                    (seq[i] >= 0) ? seq[i] : 0, (seq[i] < 0) ? 1 : 0, (i == 11) ? 1 : 0, 0);
        end
        for (int i = 1; i < 11; i++) begin
            tick();
            chk_out($sformatf("scan_p2_%0d", i), 2, (seq[i] >= 0) ? 1 : 0,
                    (seq[i] >= 0) ? seq[i] : 0, (seq[i] < 0) ? 1 : 0, 0, 0);
        end
        // dwell expires at address 3 in this cycle, but EN_in drops
        en = 1'b0;
        tick();
        chk_out("en_off_expiry", 2, 0, 0, 0, 0, 0);

        // scan -> direct switch on d0 while driving address 1
        do_reset();
        mode = 1'b1; dwell = 8'd3; en = 1'b1;
        repeat (9) tick();
        chk_out("scan_at1", 0, 1, 1, 0, 0, 0);
        mode = 1'b0; a = 3'd2;
        tick();
        chk_out("sw_brk1", 0, 0, 0, 1, 0, 0);
        tick();
        chk_out("sw_brk2", 0, 0, 0, 1, 0, 0);
        tick();
        chk_out("sw_drv2", 0, 1, 2, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk_out($sformatf("sw_hold%0d", i), 0, 1, 2, 0, 0, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
